comparator_nway: RTL and testbench

Parametrised N-channel, W-bit compare-select pipeline, the successor of the 1-bit four-input comparator. Each accepted beat carries CHANNELS unsigned or signed words. The block returns the extreme value (max or min, chosen per beat), its channel index and an all-equal flag after a fixed pipeline latency. An optional running-extremum register tracks the extreme across beats until cleared. It sits between sample capture and the threshold/decision logic in the comparator datapath.

---
 rtl/comparator_nway_pkg.sv | 22 ++
 rtl/comparator_nway_cmp_node.sv | 44 ++++
 rtl/comparator_nway.sv | 143 ++++++++++++++
 tb/tb_comparator_nway.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_nway_pkg.sv
// Shared definitions for the N-way compare-select datapath.
package comparator_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  // Ceiling log2 for elaboration-time sizing (returns 0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/comparator_nway_cmp_node.sv
// Combinational two-input compare-select node: picks the more extreme
// value under the given mode, lower index wins ties, and propagates the
// all-equal flag of the subtree.
module cmp_node
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IW     = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] l_value,
  input  logic [IW-1:0]    l_index,
  input  logic             l_equal,
  input  logic [WIDTH-1:0] r_value,
  input  logic [IW-1:0]    r_index,
  input  logic             r_equal,
  output logic [WIDTH-1:0] o_value,
  output logic [IW-1:0]    o_index,
  output logic             o_equal
);

  // True when a is strictly more extreme than b under mode m.
  function automatic logic beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input mode_e m);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    ea = {(SIGNED ? a[WIDTH-1] : 1'b0), a};
    eb = {(SIGNED ? b[WIDTH-1] : 1'b0), b};
    return (m == MODE_MAX) ? (ea > eb) : (ea < eb);
  endfunction

  logic pick_r;

  // Select right only if strictly better, or tied with a lower index.
  always_comb begin
    pick_r  = beats(r_value, l_value, mode_e'(mode)) ||
              ((r_value == l_value) && (r_index < l_index));
    o_value = pick_r ? r_value : l_value;
    o_index = pick_r ? r_index : l_index;
    o_equal = l_equal && r_equal && (l_value == r_value);
  end

endmodule

// File: rtl/comparator_nway.sv
// N-channel compare-select pipeline: leaf capture register followed by one
// registered tree level per compare stage, global stall backpressure and a
// running-extremum accumulator on the output handshake.
module comparator_nway
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter bit          SIGNED   = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic                          in_mode,
  input  logic                          acc_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_value,
  output logic [clog2(CHANNELS)-1:0]    out_index,
  output logic                          out_all_equal,
  output logic                          acc_valid,
  output logic [WIDTH-1:0]              acc_value,
  output logic [clog2(CHANNELS)-1:0]    acc_index
);

  localparam int unsigned STAGES = clog2(CHANNELS);
  localparam int unsigned IW     = STAGES;
  localparam int unsigned NODES  = CHANNELS - 1;

  // Tree nodes are stored level by level: level l starts at CHANNELS - 2*(CHANNELS>>l).
  logic [WIDTH-1:0] leaf  [CHANNELS];
  logic [WIDTH-1:0] t_val [NODES];
  logic [IW-1:0]    t_idx [NODES];
  logic             t_eq  [NODES];
  logic [WIDTH-1:0] n_val [NODES];
  logic [IW-1:0]    n_idx [NODES];
  logic             n_eq  [NODES];
  logic [STAGES:0]  vld;
  mode_e            mode  [STAGES+1];
  logic             stall;
  logic             fire_out;

  function automatic logic beats(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input mode_e m);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    ea = {(SIGNED ? a[WIDTH-1] : 1'b0), a};
    eb = {(SIGNED ? b[WIDTH-1] : 1'b0), b};
    return (m == MODE_MAX) ? (ea > eb) : (ea < eb);
  endfunction

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign fire_out = out_valid && out_ready;

  assign out_valid     = vld[STAGES];
  assign out_value     = t_val[NODES-1];
  assign out_index     = t_idx[NODES-1];
  assign out_all_equal = t_eq[NODES-1];

  for (genvar l = 1; l <= STAGES; l++) begin : g_lvl
    localparam int unsigned N   = CHANNELS >> l;
    localparam int unsigned OFS = CHANNELS - 2 * (CHANNELS >> l);
    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 1) begin : g_leaf_in
        cmp_node #(.WIDTH(WIDTH), .IW(IW), .SIGNED(SIGNED)) u_node (
          .mode    (mode[0]),
          .l_value (leaf[2*j]),
          .l_index (IW'(2*j)),
          .l_equal (1'b1),
          .r_value (leaf[2*j+1]),
          .r_index (IW'(2*j+1)),
          .r_equal (1'b1),
          .o_value (n_val[OFS+j]),
          .o_index (n_idx[OFS+j]),
          .o_equal (n_eq[OFS+j])
        );
      end else begin : g_tree_in
        localparam int unsigned PO = CHANNELS - 2 * (CHANNELS >> (l-1));
        cmp_node #(.WIDTH(WIDTH), .IW(IW), .SIGNED(SIGNED)) u_node (
          .mode    (mode[l-1]),
          .l_value (t_val[PO+2*j]),
          .l_index (t_idx[PO+2*j]),
          .l_equal (t_eq[PO+2*j]),
          .r_value (t_val[PO+2*j+1]),
          .r_index (t_idx[PO+2*j+1]),
          .r_equal (t_eq[PO+2*j+1]),
          .o_value (n_val[OFS+j]),
          .o_index (n_idx[OFS+j]),
          .o_equal (n_eq[OFS+j])
        );
      end
    end
  end

  // Pipeline registers: every stage advances together unless the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned s = 0; s <= STAGES; s++) mode[s] <= MODE_MAX;
      for (int unsigned k = 0; k < CHANNELS; k++) leaf[k] <= '0;
      for (int unsigned i = 0; i < NODES; i++) begin
        t_val[i] <= '0;
        t_idx[i] <= '0;
        t_eq[i]  <= 1'b0;
      end
    end else if (!stall) begin
      vld[0]  <= in_valid;
      mode[0] <= mode_e'(in_mode);
      for (int unsigned s = 1; s <= STAGES; s++) begin
        vld[s]  <= vld[s-1];
        mode[s] <= mode[s-1];
      end
      for (int unsigned k = 0; k < CHANNELS; k++) leaf[k] <= in_data[k*WIDTH +: WIDTH];
      for (int unsigned i = 0; i < NODES; i++) begin
        t_val[i] <= n_val[i];
        t_idx[i] <= n_idx[i];
        t_eq[i]  <= n_eq[i];
      end
    end
  end

  // Running extremum: clear dominates; otherwise load/replace on handshake,
  // ties keep the older entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc_value <= '0;
      acc_index <= '0;
    end else if (acc_clear) begin
      acc_valid <= 1'b0;
      acc_value <= '0;
      acc_index <= '0;
    end else if (fire_out && (!acc_valid || beats(out_value, acc_value, mode[STAGES]))) begin
      acc_valid <= 1'b1;
      acc_value <= out_value;
      acc_index <= out_index;
    end
  end

endmodule

// File: tb/tb_comparator_nway.sv
// Bench for comparator_nway: unsigned and signed instances on shared stimulus,
// checked every cycle against a beat-level reference model plus literal pins.
module tb_comparator_nway;

  localparam int ST = 2;

  typedef struct packed {
    logic [7:0] v;
    logic [1:0] ix;
    logic       eq;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_mode;
  logic        acc_clear;
  logic        out_ready;

  logic       u_in_ready, u_out_valid, u_out_all_equal, u_acc_valid;
  logic [7:0] u_out_value, u_acc_value;
  logic [1:0] u_out_index, u_acc_index;
  logic       s_in_ready, s_out_valid, s_out_all_equal, s_acc_valid;
  logic [7:0] s_out_value, s_acc_value;
  logic [1:0] s_out_index, s_acc_index;

  int checks   = 0;
  int failures = 0;

  res_t        log_u[$];
  res_t        log_s[$];
  logic [31:0] sent[$];

  // Reference model state: beats in flight (latency slots) and accumulators.
  logic        m_vld  [0:ST] = '{default: 1'b0};
  logic [31:0] m_data [0:ST] = '{default: 32'd0};
  logic        m_mode [0:ST] = '{default: 1'b0};
  logic        ma_vld [2]    = '{default: 1'b0};
  logic [7:0]  ma_val [2]    = '{default: 8'd0};
  logic [1:0]  ma_idx [2]    = '{default: 2'd0};

  comparator_nway #(.WIDTH(8), .CHANNELS(4), .SIGNED(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_data(in_data), .in_mode(in_mode), .acc_clear(acc_clear),
    .out_valid(u_out_valid), .out_ready(out_ready), .out_value(u_out_value),
    .out_index(u_out_index), .out_all_equal(u_out_all_equal),
    .acc_valid(u_acc_valid), .acc_value(u_acc_value), .acc_index(u_acc_index)
  );

  comparator_nway #(.WIDTH(8), .CHANNELS(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_mode(in_mode), .acc_clear(acc_clear),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_value(s_out_value),
    .out_index(s_out_index), .out_all_equal(s_out_all_equal),
    .acc_valid(s_acc_valid), .acc_value(s_acc_value), .acc_index(s_acc_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int as_int(input logic [7:0] w, input bit sgn);
    return sgn ? int'($signed(w)) : int'(w);
  endfunction

  // Extreme of a beat by scanning channels; strict improvement keeps lowest index.
  function automatic void ref_beat(input logic [31:0] d, input logic m, input bit sgn,
                                   output logic [7:0] v, output logic [1:0] ix,
                                   output logic eq);
    int         best;
    int         cur;
    logic [7:0] w;
    best = 0;
    v    = d[7:0];
    ix   = 2'd0;
    eq   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w   = d[k*8 +: 8];
      cur = as_int(w, sgn);
      if (k == 0 || (m == 1'b0 ? cur > best : cur < best)) begin
        best = cur;
        v    = w;
        ix   = 2'(k);
      end
      if (w != d[7:0]) eq = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] v;
    logic [1:0] ix;
    logic       eq;
    if (rst) begin
      for (int s = 0; s <= ST; s++) m_vld[s] <= 1'b0;
      for (int s = 0; s < 2; s++) ma_vld[s] <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (acc_clear) begin
          ma_vld[s] <= 1'b0;
        end else if (m_vld[ST] && out_ready) begin
          ref_beat(m_data[ST], m_mode[ST], s[0], v, ix, eq);
          if (!ma_vld[s] || (m_mode[ST] == 1'b0 ? as_int(v, s[0]) > as_int(ma_val[s], s[0])
                                                : as_int(v, s[0]) < as_int(ma_val[s], s[0]))) begin
            ma_vld[s] <= 1'b1;
            ma_val[s] <= v;
            ma_idx[s] <= ix;
          end
        end
      end
      if (!(m_vld[ST] && !out_ready)) begin
        for (int s = ST; s > 0; s--) begin
          m_vld[s]  <= m_vld[s-1];
          m_data[s] <= m_data[s-1];
          m_mode[s] <= m_mode[s-1];
        end
        m_vld[0]  <= in_valid;
        m_data[0] <= in_data;
        m_mode[0] <= in_mode;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] v;
    logic [1:0] ix;
    logic       eq;
    logic       mr;
    mr = !(m_vld[ST] && !out_ready);
    chk("u_in_ready", u_in_ready, mr);
    chk("s_in_ready", s_in_ready, mr);
    chk("u_out_valid", u_out_valid, m_vld[ST]);
    chk("s_out_valid", s_out_valid, m_vld[ST]);
    if (m_vld[ST]) begin
      ref_beat(m_data[ST], m_mode[ST], 1'b0, v, ix, eq);
      chk("u_out_value", u_out_value, v);
      chk("u_out_index", u_out_index, ix);
      chk("u_out_all_equal", u_out_all_equal, eq);
      ref_beat(m_data[ST], m_mode[ST], 1'b1, v, ix, eq);
      chk("s_out_value", s_out_value, v);
      chk("s_out_index", s_out_index, ix);
      chk("s_out_all_equal", s_out_all_equal, eq);
    end
    chk("u_acc_valid", u_acc_valid, ma_vld[0]);
    chk("s_acc_valid", s_acc_valid, ma_vld[1]);
    if (ma_vld[0]) begin
      chk("u_acc_value", u_acc_value, ma_val[0]);
      chk("u_acc_index", u_acc_index, ma_idx[0]);
    end
    if (ma_vld[1]) begin
      chk("s_acc_value", s_acc_value, ma_val[1]);
      chk("s_acc_index", s_acc_index, ma_idx[1]);
    end
    if (!rst && u_out_valid && out_ready) log_u.push_back(res_t'{u_out_value, u_out_index, u_out_all_equal});
    if (!rst && s_out_valid && out_ready) log_s.push_back(res_t'{s_out_value, s_out_index, s_out_all_equal});
  end

  task automatic send(input logic [31:0] d, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (u_in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=no_accept required=accept_within_20");
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    bit seen;
    logic [7:0] v;
    logic [1:0] ix;
    logic       eq;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    acc_clear = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", u_out_valid, 0);
    chk("rst_out_value", u_out_value, 0);
    chk("rst_acc_valid", u_acc_valid, 0);
    chk("rst_in_ready", u_in_ready, 1);
    rst = 1'b0;

    // Directed beats with literal results.
    send({8'd7, 8'd2, 8'd9, 8'd3}, 1'b0);
    send({8'd7, 8'd2, 8'd9, 8'd3}, 1'b1);
    send({8'd5, 8'd5, 8'd5, 8'd5}, 1'b1);
    send({8'd1, 8'd8, 8'd8, 8'd6}, 1'b0);
    send({8'h00, 8'h80, 8'h01, 8'hFF}, 1'b1);
    drain(6);
    chk("a_count", log_u.size(), 5);
    chk("a_count_s", log_s.size(), 5);
    if (log_u.size() >= 5 && log_s.size() >= 5) begin
      chk("a0_value", log_u[0].v, 9);  chk("a0_index", log_u[0].ix, 1); chk("a0_eq", log_u[0].eq, 0);
      chk("a1_value", log_u[1].v, 2);  chk("a1_index", log_u[1].ix, 2);
      chk("a2_value", log_u[2].v, 5);  chk("a2_index", log_u[2].ix, 0); chk("a2_eq", log_u[2].eq, 1);
      chk("a3_value", log_u[3].v, 8);  chk("a3_index", log_u[3].ix, 1);
      chk("a4_value_u", log_u[4].v, 8'h00); chk("a4_index_u", log_u[4].ix, 3);
      chk("a4_value_s", log_s[4].v, 8'h80); chk("a4_index_s", log_s[4].ix, 2);
    end

    // Back-to-back beats with a 3-cycle output stall in the middle.
    base = log_u.size();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          sent.push_back({8'(i*3+1), 8'(20-i), 8'(i*7), 8'd11});
          send({8'(i*3+1), 8'(20-i), 8'(i*7), 8'd11}, 1'(i % 2));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(8);
    chk("b_count", log_u.size() - base, 6);
    if (log_u.size() - base == 6) begin
      for (int i = 0; i < 6; i++) begin
        ref_beat(sent[i], 1'(i % 2), 1'b0, v, ix, eq);
        chk("b_order_value", log_u[base+i].v, v);
        chk("b_order_index", log_u[base+i].ix, ix);
      end
    end

    // Accumulator: maxima 4, 9 (ch1), 9 (ch0), 3.
    acc_clear = 1'b1;
    @(posedge clk);
    #1 acc_clear = 1'b0;
    chk("c_clear_idle", u_acc_valid, 0);
    send({8'd2, 8'd0, 8'd1, 8'd4}, 1'b0);
    send({8'd0, 8'd3, 8'd9, 8'd1}, 1'b0);
    send({8'd2, 8'd2, 8'd2, 8'd9}, 1'b0);
    send({8'd1, 8'd0, 8'd3, 8'd3}, 1'b0);
    drain(6);
    chk("c_acc_valid", u_acc_valid, 1);
    chk("c_acc_value", u_acc_value, 9);
    chk("c_acc_index", u_acc_index, 1);

    // Clear coinciding with a handshake of max 12.
    send({8'd0, 8'd0, 8'd0, 8'd12}, 1'b0);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (u_out_valid) seen = 1'b1;
    end
    chk("c_wait_out_valid", seen, 1);
    acc_clear = 1'b1;
    @(posedge clk);
    #1 acc_clear = 1'b0;
    chk("c_clear_on_hs", u_acc_valid, 0);
    send({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0);
    drain(6);
    chk("c_reload_valid", u_acc_valid, 1);
    chk("c_reload_value", u_acc_value, 4);
    chk("c_reload_index", u_acc_index, 3);

    // Asynchronous reset with two beats in flight.
    send({8'd7, 8'd2, 8'd9, 8'd3}, 1'b0);
    send({8'd1, 8'd8, 8'd8, 8'd6}, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("d_out_valid", u_out_valid, 0);
    chk("d_out_value", u_out_value, 0);
    chk("d_out_index", u_out_index, 0);
    chk("d_out_all_equal", u_out_all_equal, 0);
    chk("d_acc_valid", u_acc_valid, 0);
    chk("d_acc_value", u_acc_value, 0);
    chk("d_acc_index", u_acc_index, 0);
    chk("d_in_ready", u_in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("d_no_stale", u_out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
